// File: rtl/hpi_pkg.sv
// Shared HPI register map and status-word layout for the HPI responder slice.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    localparam int unsigned STAT_INT_BIT   = 0;
    localparam int unsigned STAT_MBXIN_BIT = 8;

    function automatic logic [15:0] status_word(input logic mbx_in_valid, input logic int_pend);
        logic [15:0] s;
        s                 = '0;
        s[STAT_INT_BIT]   = int_pend;
        s[STAT_MBXIN_BIT] = mbx_in_valid;
        return s;
    endfunction

endpackage

// File: rtl/hpi_dpram.sv
// True dual-port 16-bit RAM, read-first, registered reads; port A wins a same-word write collision.
module hpi_dpram #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          srst_i,
    input  logic          a_en_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [15:0]   a_wdata_i,
    output logic [15:0]   a_rdata_o,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [15:0]   b_wdata_i,
    output logic [15:0]   b_rdata_o
);

    logic [15:0] mem_q [WORDS];
    logic [15:0] a_rdata_q;
    logic [15:0] b_rdata_q;

    // Port A written last so the host write survives a collision with the local port.
    always_ff @(posedge clk_i) begin
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (srst_i) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/hpi_slave_responder.sv
// HPI responder: strobe edge detect, address pointer, mailboxes and the tri-state data bus
// in front of a shared dual-port memory.
module hpi_slave_responder
    import hpi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [15:0] PTR_RESET = 16'h0000,
    localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [1:0]    OTG_ADDR,
    input  logic          OTG_CS_N,
    input  logic          OTG_RD_N,
    input  logic          OTG_WR_N,
    input  logic          OTG_RST_N,
    inout  wire  [15:0]   OTG_DATA,
    output logic          OTG_INT,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [15:0]   loc_wdata,
    output logic [15:0]   loc_rdata,
    input  logic          mbx_out_we,
    input  logic [15:0]   mbx_out_data,
    output logic [15:0]   mbx_in_data,
    output logic          mbx_in_valid,
    input  logic          mbx_in_ack
);

    hpi_reg_e    reg_sel;
    logic        act, commit, wr_cmt, rd_cmt, srst, drive;
    logic        act_q;
    logic [15:0] ptr_q, ptr_d;
    logic        int_q, int_d;
    logic [15:0] out_q, out_d;
    logic [15:0] in_data_q, in_data_d;
    logic        in_valid_q, in_valid_d;
    logic [15:0] rd_q, rd_d;
    logic        sel_mem_q, sel_mem_d;
    logic [15:0] mem_rdata;
    logic [15:0] bus_data;

    assign reg_sel = hpi_reg_e'(OTG_ADDR);
    assign srst    = ~OTG_RST_N;
    assign act     = ~OTG_CS_N & (~OTG_RD_N | ~OTG_WR_N);
    assign commit  = act & ~act_q & OTG_RST_N;
    assign wr_cmt  = commit & ~OTG_WR_N;
    assign rd_cmt  = commit & OTG_WR_N;

    always_comb begin
        ptr_d      = ptr_q;
        int_d      = int_q;
        out_d      = out_q;
        in_data_d  = in_data_q;
        in_valid_d = in_valid_q;
        rd_d       = rd_q;
        sel_mem_d  = sel_mem_q;

        if (mbx_in_ack) in_valid_d = 1'b0;

        if (wr_cmt) begin
            unique case (reg_sel)
                HPI_DATA:    ptr_d = ptr_q + 16'd2;
                HPI_MAILBOX: begin
                    in_data_d  = OTG_DATA;
                    in_valid_d = 1'b1;
                end
                HPI_ADDRESS: ptr_d = {OTG_DATA[15:1], 1'b0};
                HPI_STATUS:  ;
            endcase
        end

        if (rd_cmt) begin
            sel_mem_d = (reg_sel == HPI_DATA);
            unique case (reg_sel)
                HPI_DATA:    ptr_d = ptr_q + 16'd2;
                HPI_MAILBOX: begin
                    rd_d  = out_q;
                    int_d = 1'b0;
                end
                HPI_ADDRESS: rd_d = ptr_q;
                HPI_STATUS:  rd_d = status_word(in_valid_q, int_q);
            endcase
        end

        // A local mailbox load overrides a same-cycle host read clearing the interrupt.
        if (mbx_out_we) begin
            out_d = mbx_out_data;
            int_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            act_q      <= 1'b0;
            ptr_q      <= PTR_RESET;
            int_q      <= 1'b0;
            out_q      <= '0;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            rd_q       <= '0;
            sel_mem_q  <= 1'b0;
        end else if (srst) begin
            act_q      <= 1'b0;
            ptr_q      <= PTR_RESET;
            int_q      <= 1'b0;
            out_q      <= '0;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            rd_q       <= '0;
            sel_mem_q  <= 1'b0;
        end else begin
            act_q      <= act;
            ptr_q      <= ptr_d;
            int_q      <= int_d;
            out_q      <= out_d;
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            rd_q       <= rd_d;
            sel_mem_q  <= sel_mem_d;
        end
    end

    // Memory reads land in the RAM output register, which only reloads on a DATA read commit.
    hpi_dpram #(
        .WORDS(MEM_WORDS),
        .AW   (AW)
    ) u_mem (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .srst_i   (srst),
        .a_en_i   (rd_cmt && reg_sel == HPI_DATA),
        .a_we_i   (wr_cmt && reg_sel == HPI_DATA),
        .a_addr_i (ptr_q[AW:1]),
        .a_wdata_i(OTG_DATA),
        .a_rdata_o(mem_rdata),
        .b_we_i   (loc_we),
        .b_addr_i (loc_addr),
        .b_wdata_i(loc_wdata),
        .b_rdata_o(loc_rdata)
    );

    assign bus_data     = sel_mem_q ? mem_rdata : rd_q;
    assign drive        = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N & OTG_RST_N & Reset_n;
    assign OTG_DATA     = drive ? bus_data : 'z;
    assign OTG_INT      = int_q;
    assign mbx_in_data  = in_data_q;
    assign mbx_in_valid = in_valid_q;

endmodule

// File: tb/tb_hpi_slave_responder.sv
// Directed and randomized bench for hpi_slave_responder against a register-level reference model.
module tb_hpi_slave_responder;

    localparam int unsigned TB_WORDS = 256;
    localparam int unsigned TB_AW    = 8;

    logic              Clk = 1'b0;
    logic              Reset_n, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N;
    logic [1:0]        OTG_ADDR;
    wire  [15:0]       OTG_DATA;
    logic              tb_oe;
    logic [15:0]       tb_data;
    logic              OTG_INT;
    logic              loc_we;
    logic [TB_AW-1:0]  loc_addr;
    logic [15:0]       loc_wdata, loc_rdata;
    logic              mbx_out_we;
    logic [15:0]       mbx_out_data, mbx_in_data;
    logic              mbx_in_valid, mbx_in_ack;

    assign OTG_DATA = tb_oe ? tb_data : 'z;
    always #5 Clk = ~Clk;

    hpi_slave_responder #(
        .MEM_WORDS(TB_WORDS),
        .PTR_RESET(16'h0000)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .OTG_ADDR(OTG_ADDR), .OTG_CS_N(OTG_CS_N),
        .OTG_RD_N(OTG_RD_N), .OTG_WR_N(OTG_WR_N), .OTG_RST_N(OTG_RST_N),
        .OTG_DATA(OTG_DATA), .OTG_INT(OTG_INT), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .mbx_out_we(mbx_out_we),
        .mbx_out_data(mbx_out_data), .mbx_in_data(mbx_in_data),
        .mbx_in_valid(mbx_in_valid), .mbx_in_ack(mbx_in_ack)
    );

    // Reference model: register-level view of the chip.
    logic [15:0] m_mem [TB_WORDS];
    logic [15:0] m_ptr, m_out, m_in;
    logic        m_int, m_vin;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic int unsigned m_idx(input logic [15:0] p);
        return (int'(p) / 2) % TB_WORDS;
    endfunction

    task automatic m_reset();
        m_ptr = 16'h0000; m_out = '0; m_in = '0; m_int = 1'b0; m_vin = 1'b0;
    endtask

    task automatic m_write(input logic [1:0] a, input logic [15:0] d);
        case (a)
            2'd0: begin m_mem[m_idx(m_ptr)] = d; m_ptr = m_ptr + 16'd2; end
            2'd1: begin m_in = d; m_vin = 1'b1; end
            2'd2: m_ptr = d & 16'hFFFE;
            default: ;
        endcase
    endtask

    task automatic m_read(input logic [1:0] a, output logic [15:0] v);
        case (a)
            2'd0: begin v = m_mem[m_idx(m_ptr)]; m_ptr = m_ptr + 16'd2; end
            2'd1: begin v = m_out; m_int = 1'b0; end
            2'd2: v = m_ptr;
            default: v = (m_vin ? 16'h0100 : 16'h0000) | (m_int ? 16'h0001 : 16'h0000);
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_rel(input string tag);
        n_tests++;
        assert (OTG_DATA === 16'hzzzz || OTG_DATA === 16'h0000) else begin
            n_fail++;
            $error("FAIL %s: bus got %h expected released", tag, OTG_DATA);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".int"}, {15'b0, OTG_INT}, {15'b0, m_int});
        chk({tag, ".vin"}, {15'b0, mbx_in_valid}, {15'b0, m_vin});
        chk({tag, ".din"}, mbx_in_data, m_in);
    endtask

    task automatic bus_idle();
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [15:0] d, input int unsigned hold);
        @(posedge Clk); #1;
        OTG_ADDR = a; tb_data = d; tb_oe = 1'b1; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
        @(posedge Clk); #1;
        m_write(a, d);
        for (int unsigned i = 1; i < hold; i++) begin @(posedge Clk); #1; end
        bus_idle();
    endtask

    task automatic host_rd(input string tag, input logic [1:0] a, input int unsigned hold);
        logic [15:0] e;
        @(posedge Clk); #1;
        OTG_ADDR = a; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        @(posedge Clk); #1;
        m_read(a, e);
        chk(tag, OTG_DATA, e);
        for (int unsigned i = 1; i < hold; i++) begin
            @(posedge Clk); #1;
            chk({tag, ".hold"}, OTG_DATA, e);
        end
        bus_idle();
        #1 chk_rel({tag, ".rel"});
    endtask

    task automatic loc_wr(input logic [TB_AW-1:0] a, input logic [15:0] d);
        @(posedge Clk); #1;
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(posedge Clk); #1;
        loc_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic loc_rd(input string tag, input logic [TB_AW-1:0] a);
        @(posedge Clk); #1;
        loc_addr = a;
        @(posedge Clk); #1;
        chk(tag, loc_rdata, m_mem[a]);
    endtask

    task automatic mbx_out(input logic [15:0] d);
        @(posedge Clk); #1;
        mbx_out_we = 1'b1; mbx_out_data = d;
        @(posedge Clk); #1;
        mbx_out_we = 1'b0;
        m_out = d; m_int = 1'b1;
    endtask

    task automatic ack();
        @(posedge Clk); #1;
        mbx_in_ack = 1'b1;
        @(posedge Clk); #1;
        mbx_in_ack = 1'b0;
        m_vin = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e;
        logic [15:0] old;
        int unsigned op;

        Reset_n = 1'b0; OTG_RST_N = 1'b1; OTG_ADDR = 2'd0; tb_data = '0;
        bus_idle();
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        mbx_out_we = 1'b0; mbx_out_data = '0; mbx_in_ack = 1'b0;
        m_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk_state("reset");
        chk("reset.loc_rdata", loc_rdata, 16'h0000);
        chk_rel("reset.bus");
        Reset_n = 1'b1;

        for (int unsigned i = 0; i < TB_WORDS; i++)
            loc_wr(TB_AW'(i), 16'hA05A ^ 16'(i * 32'h0107));

        // 1: host writes, read back locally
        host_wr(2'd2, 16'h0100, 1);
        host_wr(2'd0, 16'hAAAA, 1);
        host_wr(2'd0, 16'h5555, 2);
        host_rd("t1.ptr", 2'd2, 1);
        loc_rd("t1.w80", 8'h80);
        loc_rd("t1.w81", 8'h81);

        // 2: local write, host reads
        loc_wr(8'h10, 16'h1234);
        host_wr(2'd2, 16'h0020, 1);
        host_rd("t2.rd0", 2'd0, 2);
        host_rd("t2.rd1", 2'd0, 1);
        host_rd("t2.ptr", 2'd2, 1);

        // 3: long write strobe commits once
        host_wr(2'd0, 16'hC0DE, 5);
        host_rd("t3.ptr", 2'd2, 1);
        loc_rd("t3.mem", 8'h12);
        loc_rd("t3.next", 8'h13);

        // 4: outbound mailbox
        mbx_out(16'hBEEF);
        chk_state("t4.set");
        host_rd("t4.stat", 2'd3, 1);
        host_rd("t4.mbx", 2'd1, 3);
        chk_state("t4.clr");

        // 5: inbound mailbox, ack colliding with host write
        host_wr(2'd1, 16'h00C0, 1);
        chk_state("t5.wr");
        @(posedge Clk); #1;
        OTG_ADDR = 2'd1; tb_data = 16'h00C1; tb_oe = 1'b1; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
        mbx_in_ack = 1'b1;
        @(posedge Clk); #1;
        mbx_in_ack = 1'b0; bus_idle();
        m_in = 16'h00C1; m_vin = 1'b1;
        chk_state("t5.ackcoll");
        ack();
        chk_state("t5.ack");

        // mailbox load colliding with a host MAILBOX read
        mbx_out(16'h1111);
        @(posedge Clk); #1;
        OTG_ADDR = 2'd1; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        mbx_out_we = 1'b1; mbx_out_data = 16'h2222;
        @(posedge Clk); #1;
        mbx_out_we = 1'b0;
        chk("mbxcoll.rd", OTG_DATA, 16'h1111);
        bus_idle();
        m_out = 16'h2222; m_int = 1'b1;
        chk_state("mbxcoll");
        host_rd("mbxcoll.new", 2'd1, 1);

        // host and local write to the same word in one cycle
        host_wr(2'd2, 16'h0040, 1);
        old = m_mem[8'h20];
        @(posedge Clk); #1;
        OTG_ADDR = 2'd0; tb_data = 16'hF00D; tb_oe = 1'b1; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
        loc_we = 1'b1; loc_addr = 8'h20; loc_wdata = 16'h0BAD;
        @(posedge Clk); #1;
        loc_we = 1'b0; bus_idle();
        chk("coll.readfirst", loc_rdata, old);
        m_write(2'd0, 16'hF00D);
        loc_rd("coll.host", 8'h20);

        // 6: pointer wrap and aliasing
        host_wr(2'd2, 16'hFFFE, 1);
        host_wr(2'd0, 16'h7E57, 1);
        host_rd("t6.wrap", 2'd2, 1);
        loc_rd("t6.alias", 8'hFF);

        // soft reset mid-strobe
        mbx_out(16'h3333);
        host_wr(2'd1, 16'h4444, 1);
        @(posedge Clk); #1;
        OTG_ADDR = 2'd3; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        @(posedge Clk); #1;
        m_read(2'd3, e);
        chk("srst.stat", OTG_DATA, e);
        OTG_RST_N = 1'b0;
        #1 chk_rel("srst.bus");
        @(posedge Clk); #1;
        OTG_RST_N = 1'b1; bus_idle();
        m_reset();
        chk_state("srst");
        chk("srst.loc_rdata", loc_rdata, 16'h0000);
        host_rd("srst.ptr", 2'd2, 1);

        // async reset mid-read; held strobe commits once after release
        mbx_out(16'h5555);
        host_wr(2'd1, 16'h6666, 1);
        host_wr(2'd2, 16'h0010, 1);
        @(posedge Clk); #1;
        OTG_ADDR = 2'd0; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        @(posedge Clk); #1;
        m_read(2'd0, e);
        chk("arst.pre", OTG_DATA, e);
        Reset_n = 1'b0;
        #1;
        m_reset();
        chk_state("arst");
        chk("arst.loc_rdata", loc_rdata, 16'h0000);
        chk_rel("arst.bus");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        m_read(2'd0, e);
        chk("arst.recommit", OTG_DATA, e);
        @(posedge Clk); #1;
        chk("arst.once", OTG_DATA, e);
        bus_idle();
        host_rd("arst.ptr", 2'd2, 1);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: host_wr(2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(1, 3));
                3, 4, 5: host_rd("rnd.rd", 2'($urandom_range(0, 3)), $urandom_range(1, 3));
                6:       loc_wr(TB_AW'($urandom), 16'($urandom));
                7:       loc_rd("rnd.loc", TB_AW'($urandom));
                8:       mbx_out(16'($urandom));
                default: ack();
            endcase
            chk_state("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
